mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (posedge) and reset.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request, level
- if_addr  in  32  fetch byte address
- if_ack  out  1  fetch complete, 1-cycle pulse
- if_rdata  out  32  fetched word, valid while if_ack=1
- d_req  in  1  data request, level
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  data byte enables
- d_ack  out  1  data complete, 1-cycle pulse
- d_rdata  out  32  load word, valid while d_ack=1
- waitrequest  in  1  bus stall
- readdata  in  32  bus read data
- address  out  32  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  bus write data
- byteenable  out  4  bus byte enables
- busy  out  1  high in any state other than IDLE

Function
REQ-003 FSM SHALL have states IDLE, BUS, RESP.
REQ-004 IDLE: if any unmasked request is present, capture the winner's address, we, wdata and be into internal registers, record the owner, and go to BUS; otherwise stay in IDLE.
REQ-005 Priority SHALL be fixed: d_req wins over if_req when both are sampled in the same IDLE cycle, and fetch is granted on a later IDLE.
REQ-006 BUS: address, writedata and byteenable SHALL come only from the captured registers and stay stable until waitrequest=0.
- read = owner is fetch, or owner is data with we=0.
- write = owner is data with we=1.
REQ-007 A fetch grant SHALL drive byteenable=4'b1111 and write=0; a data grant SHALL drive byteenable=captured d_be.
REQ-008 BUS SHALL exit to RESP on the first cycle with waitrequest=0, registering readdata into the owner's rdata register on a read; while waitrequest=1 it SHALL remain in BUS, unbounded.
REQ-009 RESP SHALL assert exactly the owner's ack for one cycle, hold read=write=0, then go to IDLE.
REQ-010 Minimum latency SHALL be: request sampled at edge N; strobe during cycle N+1; ack during cycle N+2 when waitrequest=0.
REQ-011 Each extra cycle of waitrequest=1 SHALL add exactly one cycle of latency.
REQ-012 Requesters SHALL hold req and their operands stable until ack, and deassert req in the ack cycle.
REQ-013 The arbiter SHALL mask the just-served requester's req during the IDLE cycle immediately after its RESP, so no duplicate grant occurs.
REQ-014 if_rdata and d_rdata SHALL hold their last value between acks; a store SHALL not modify d_rdata.
REQ-015 Request inputs that change while in BUS or RESP SHALL have no effect on the current transaction.
REQ-016 read and write SHALL never be high in the same cycle, and at most one ack SHALL be high per cycle.

Reset
REQ-017 reset=1 at an edge SHALL force IDLE and clear every output and internal register to 0, including address, writedata, byteenable, rdata, owner and mask.
REQ-018 Reset during BUS or RESP SHALL abort the transaction: strobes low from the next cycle, no ack issued, captured request discarded.
REQ-019 reset SHALL take precedence over every other event in the same cycle.

Structure
REQ-020 Package mem_arb_pkg SHALL hold:
- the state enum (IDLE, BUS, RESP);
- the owner enum (OWN_FETCH, OWN_DATA);
- the constant FETCH_BE = 4'b1111.
REQ-021 The block SHALL be a single module with no sub-modules: the FSM and capture registers are too small to justify a split.

Verification
REQ-022 Fetch only: if_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 with address=0xBFC00000 and byteenable=1111 at N+1; if_ack=1 with if_rdata=0x24020005 at N+2.
REQ-023 Store with stall: d_we=1, d_addr=0x1004, d_wdata=0xDEADBEEF, d_be=0011, waitrequest=1 for 3 cycles -> write high 4 cycles with stable address, writedata and byteenable; d_ack at N+5; read=0 throughout.
REQ-024 Simultaneous requests: if_req and d_req (load, 0x2000) at the same edge -> data served first with d_ack; fetch granted in the following IDLE; exactly one ack of each.
REQ-025 Holdoff: requester keeps d_req=1 one cycle past d_ack -> no second data transaction starts.
REQ-026 Reset mid-BUS: assert reset during the second waitrequest=1 cycle of a load -> read=0 next cycle; no d_ack; busy=0; all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Instruction fetches always move a full word.
  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single Avalon-style memory bus.
// Data wins over fetch; the just-served master is ignored for one IDLE
// cycle so a requester still holding req after its ack is not regranted.
module mem_bus_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        busy
);

  state_t      state_q;
  state_t      state_d;
  owner_t      owner_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        mask_fetch_q;
  logic        mask_data_q;
  logic        grant_data;
  logic        grant_fetch;

  // State register; reset aborts whatever transaction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant decision and bus strobes/acks decoded from state.
  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !mask_data_q) begin
          grant_data = 1'b1;
          state_d    = BUS;
        end else if (if_req && !mask_fetch_q) begin
          grant_fetch = 1'b1;
          state_d     = BUS;
        end
      end
      BUS: begin
        read  = (owner_q == OWN_FETCH) || !we_q;
        write = (owner_q == OWN_DATA) && we_q;
        if (!waitrequest) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if_ack  = (owner_q == OWN_FETCH);
        d_ack   = (owner_q == OWN_DATA);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the winner's operands at grant, latch read data on completion,
  // and arm the one-cycle holdoff mask for whoever was just acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
      mask_fetch_q <= 1'b0;
      mask_data_q  <= 1'b0;
    end else begin
      mask_fetch_q <= (state_q == RESP) && (owner_q == OWN_FETCH);
      mask_data_q  <= (state_q == RESP) && (owner_q == OWN_DATA);
      if (grant_data) begin
        owner_q <= OWN_DATA;
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        be_q    <= d_be;
      end else if (grant_fetch) begin
        owner_q <= OWN_FETCH;
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= 32'h0;
        be_q    <= FETCH_BE;
      end
      if ((state_q == BUS) && !waitrequest && read) begin
        if (owner_q == OWN_FETCH) begin
          if_rdata_q <= readdata;
        end else begin
          d_rdata_q <= readdata;
        end
      end
    end
  end

  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule
